mem_access_ctrl: RTL
====================

// Module: mem_access_ctrl
// PURPOSE
//  Initiator side of the datapath-to-memory interface of the multicycle MIPS core.
//  Takes one load/store request per handshake from the control unit and sequences
//  memRead/memWrite strobes, a word address and write data toward the memory block.
//  It latches read data into the MDR register. Byte stores use read-modify-write,
//  so memory only needs word access.
// PARAMETERS
//  RD_LAT     1    cycles between memRead assertion and a valid memData sample (>=1)
//  ADDR_BITS  8    word-index width driven on memAddress; upper bits are zero
// PORTS
//  clk           in   1   system clock; all state updates on rising edge
//  reset         in   1   synchronous, active-high reset
//  reqValid      in   1   request present; held with its fields until accepted
//  reqReady      out  1   controller idle; transfer when reqValid&&reqReady
//  reqWrite      in   1   1=store, 0=load
//  reqSize       in   2   2'b00 byte, 2'b10 word; 2'b01/2'b11 reserved, treated as word
//  reqSigned     in   1   byte loads: 1=sign-extend, 0=zero-extend
//  reqAddr       in   32  byte address
//  reqWData      in   32  store data; byte stores use [7:0]
//  respValid     out  1   one-cycle pulse: load data or store completion
//  respData      out  32  load result (extended), valid with respValid; 0 for stores
//  misaligned    out  1   one-cycle pulse with respValid when a word access has addr[1:0]!=0
//  memAddress    out  32  word index = reqAddr[ADDR_BITS+1:2], zero-padded
//  memWriteData  out  32  word written to memory
//  memRead       out  1   read strobe
//  memWrite      out  1   write strobe, exactly one cycle per write
//  memData       in   32  memory read word
//  mdr           out  32  raw last word read from memory (MDR register)
// BEHAVIOUR
//  Reset: state IDLE; reqReady=1; respValid=0; misaligned=0; memRead=0; memWrite=0;
//   respData, mdr, memAddress and memWriteData = 0. Reset mid-operation aborts the op.
//   No memWrite is issued in the reset cycle or later for the aborted op.
//  States: IDLE, RD_WAIT, WR, RMW_RD, RMW_WR, RESP.
//  IDLE: reqReady=1. On accept, latch all req fields and drive memAddress.
//   - Word access with addr[1:0]!=0: go to RESP with misaligned=1; no strobe issued.
//   - Load: go to RD_WAIT and raise memRead.
//   - Word store: go to WR.
//   - Byte store: go to RMW_RD and raise memRead.
//  RD_WAIT/RMW_RD: memRead stays high RD_LAT cycles (counter). In the last cycle:
//   - sample memData into mdr;
//   - drop memRead in the next cycle;
//   - RD_WAIT goes to RESP; RMW_RD goes to RMW_WR.
//  WR: memWriteData=reqWData and memWrite=1 for one cycle, then go to RESP.
//  RMW_WR: memWriteData=mdr with lane addr[1:0] replaced by wdata[7:0];
//   memWrite=1 for one cycle, then go to RESP.
//  RESP: respValid=1 for one cycle; reqReady=0; next state IDLE.
//  Load result:
//   - word load: respData=mdr;
//   - byte load: lane addr[1:0] (lane0 = bits[7:0], little-endian) is extended per reqSigned.
//  Latency, accept edge to respValid:
//   - load: RD_LAT+1 cycles;
//   - word store: 2 cycles;
//   - byte store: RD_LAT+2 cycles;
//   - misaligned: 1 cycle.
//  memRead and memWrite are never high in the same cycle. reqReady=0 in every state except IDLE.
//   A request held during busy is accepted on the first IDLE cycle.
//  Back-to-back: accept is possible in the cycle after RESP.
//  memAddress is held stable from accept through RESP.
// STRUCTURE
//  Shared package mips_mem_pkg holds:
//   - SIZE_BYTE/SIZE_WORD encodings;
//   - state encoding;
//   - byte-lane extract/merge functions, also reused by the load/store decode.
//  One sub-module: mem_lane_unit (combinational). Lane extract with sign/zero
//   extension and lane merge for RMW. The FSM and counter stay in this module.
// TESTING
//  Model memory of 256 words with RD_LAT-cycle read; also run RD_LAT=1 and RD_LAT=3.
//  1 Word load, addr=0x10, mem[4]=0xDEADBEEF -> memAddress=4; respData=mdr=0xDEADBEEF
//    after RD_LAT+1 cycles.
//  2 Word store, addr=0x08, data=0x12345678 -> single memWrite pulse, memAddress=2;
//    mem[2]=0x12345678; respValid at +2.
//  3 Byte store, addr=0x0D, data=0xAB, mem[3]=0x11223344 -> read, then write;
//    mem[3]=0x1122AB44.
//  4 Byte load, addr=0x0F, mem[3]=0x80FF0000 -> signed 0xFFFFFF80;
//    unsigned 0x00000080.
//  5 Word load, addr=0x06 -> misaligned=1 and respValid 1 cycle after accept;
//    no memRead/memWrite.
//  6 Reset asserted during RMW_RD of a byte store -> no memWrite;
//    reqReady=1 next cycle; memory unchanged.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the multicycle MIPS memory access path:
// access-size encodings, controller state encoding and byte-lane helpers.
package mips_mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_WAIT = 3'd1,
        ST_WR      = 3'd2,
        ST_RMW_RD  = 3'd3,
        ST_RMW_WR  = 3'd4,
        ST_RESP    = 3'd5
    } state_e;

    // Only the byte encoding is a byte access; reserved codes behave as words.
    function automatic logic is_byte_size(input logic [1:0] size);
        return (size == SIZE_BYTE);
    endfunction

    // Pick byte lane (lane 0 = bits [7:0]) and sign- or zero-extend it.
    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  lane,
                                                 input logic        sgn);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = word[7:0];
        endcase
        return {{24{sgn & b[7]}}, b};
    endfunction

    // Replace one byte lane of a word, keeping the other three lanes.
    function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [7:0]  b);
        logic [31:0] w;
        w = word;
        case (lane)
            2'd0:    w[7:0]   = b;
            2'd1:    w[15:8]  = b;
            2'd2:    w[23:16] = b;
            2'd3:    w[31:24] = b;
            default: w[7:0]   = b;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Combinational byte-lane unit: extended lane extract for byte loads and
// lane merge for the write half of a byte-store read-modify-write.
module mem_lane_unit
    import mips_mem_pkg::*;
(
    input  logic [31:0] rd_word_i,
    input  logic [1:0]  lane_i,
    input  logic        signed_i,
    input  logic [7:0]  wbyte_i,
    output logic [31:0] ext_o,
    output logic [31:0] merge_o
);

    // Both results are pure functions of the word just read from memory
    always_comb begin
        ext_o   = lane_extract(rd_word_i, lane_i, signed_i);
        merge_o = lane_merge(rd_word_i, lane_i, wbyte_i);
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access controller of the multicycle MIPS core: accepts one load/store
// per handshake, drives word-granular memRead/memWrite strobes and returns
// the (extended) load result. Byte stores are done as read-modify-write.
module mem_access_ctrl
    import mips_mem_pkg::*;
#(
    parameter int RD_LAT    = 1,
    parameter int ADDR_BITS = 8
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [1:0]  reqSize,
    input  logic        reqSigned,
    input  logic [31:0] reqAddr,
    input  logic [31:0] reqWData,
    output logic        respValid,
    output logic [31:0] respData,
    output logic        misaligned,
    output logic [31:0] memAddress,
    output logic [31:0] memWriteData,
    output logic        memRead,
    output logic        memWrite,
    input  logic [31:0] memData,
    output logic [31:0] mdr
);

    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             signed_q, signed_d;
    logic             byte_q, byte_d;
    logic [1:0]       lane_q, lane_d;
    logic [7:0]       wbyte_q, wbyte_d;
    logic             req_ready_q, req_ready_d;
    logic             resp_valid_q, resp_valid_d;
    logic [31:0]      resp_data_q, resp_data_d;
    logic             misaligned_q, misaligned_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic             mem_read_q, mem_read_d;
    logic             mem_write_q, mem_write_d;
    logic [31:0]      mdr_q, mdr_d;

    logic             accept_s;
    logic             req_byte_s;
    logic [31:0]      ext_s;
    logic [31:0]      merge_s;
    logic             unused_addr_s;

    assign accept_s      = reqValid & req_ready_q;
    assign req_byte_s    = is_byte_size(reqSize);
    assign unused_addr_s = ^reqAddr[31:ADDR_BITS+2];

    mem_lane_unit u_lane (
        .rd_word_i (memData),
        .lane_i    (lane_q),
        .signed_i  (signed_q),
        .wbyte_i   (wbyte_q),
        .ext_o     (ext_s),
        .merge_o   (merge_s)
    );

    // Next-state and registered-output decode of the access sequencer
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        signed_d     = signed_q;
        byte_d       = byte_q;
        lane_d       = lane_q;
        wbyte_d      = wbyte_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        misaligned_d = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = 1'b0;
        mdr_d        = mdr_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    signed_d   = reqSigned;
                    byte_d     = req_byte_s;
                    lane_d     = reqAddr[1:0];
                    wbyte_d    = reqWData[7:0];
                    cnt_d      = {CNT_W{1'b0}};
                    mem_addr_d = {{(32-ADDR_BITS){1'b0}}, reqAddr[ADDR_BITS+1:2]};
                    if (!req_byte_s && (reqAddr[1:0] != 2'b00)) begin
                        // Misaligned word access: answer at once, touch no memory
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        misaligned_d = 1'b1;
                        resp_data_d  = 32'h0000_0000;
                    end else if (!reqWrite) begin
                        state_d    = ST_RD_WAIT;
                        mem_read_d = 1'b1;
                    end else if (!req_byte_s) begin
                        state_d     = ST_WR;
                        mem_write_d = 1'b1;
                        mem_wdata_d = reqWData;
                    end else begin
                        state_d    = ST_RMW_RD;
                        mem_read_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    mdr_d        = memData;
                    mem_read_d   = 1'b0;
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_data_d  = byte_q ? ext_s : memData;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RMW_RD: begin
                if (cnt_q == CNT_LAST) begin
                    // Merge the new byte into the word being latched as MDR
                    mdr_d       = memData;
                    mem_read_d  = 1'b0;
                    state_d     = ST_RMW_WR;
                    mem_write_d = 1'b1;
                    mem_wdata_d = merge_s;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WR, ST_RMW_WR: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
                resp_data_d  = 32'h0000_0000;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d    = ST_IDLE;
                mem_read_d = 1'b0;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers; reset aborts any access in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            signed_q     <= 1'b0;
            byte_q       <= 1'b0;
            lane_q       <= 2'b00;
            wbyte_q      <= 8'h00;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'h0000_0000;
            misaligned_q <= 1'b0;
            mem_addr_q   <= 32'h0000_0000;
            mem_wdata_q  <= 32'h0000_0000;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mdr_q        <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            signed_q     <= signed_d;
            byte_q       <= byte_d;
            lane_q       <= lane_d;
            wbyte_q      <= wbyte_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            misaligned_q <= misaligned_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mdr_q        <= mdr_d;
        end
    end

    assign reqReady     = req_ready_q;
    assign respValid    = resp_valid_q;
    assign respData     = resp_data_q;
    assign misaligned   = misaligned_q;
    assign memAddress   = mem_addr_q;
    assign memWriteData = mem_wdata_q;
    assign memRead      = mem_read_q;
    assign memWrite     = mem_write_q;
    assign mdr          = mdr_q;

endmodule
